// File: rtl/fifo_fc_pkg.sv
// fifo_fc_pkg: one-hot flow-control states and error-cause codes shared by fifo_fc.
package fifo_fc_pkg;
  typedef enum logic [2:0] {
    ST_RESET  = 3'b001,
    ST_NORMAL = 3'b010,
    ST_PAUSE  = 3'b100
  } fc_state_e;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UDF  = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;
endpackage

// File: rtl/fifo_fc_mem.sv
// fifo_fc_mem: DEPTH x DW dual-port RAM, sync write, registered read; reset clears only the read register.
module fifo_fc_mem #(
  parameter int AW = 3,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] data_q, data_d;
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end
  // Read-before-write: a full push+pop on the same slot returns the old word.
  always_comb data_d = !reset ? '0 : re ? ram[raddr] : data_q;
  always_ff @(posedge clk) data_q <= data_d;
  assign rdata = data_q;
endmodule

// File: rtl/fifo_fc.sv
// fifo_fc: FIFO with exact full/empty, hysteresis almost_full and error report; FIFO_FC_STICKY_ERR_EN makes errors sticky until reset.
module fifo_fc #(
  parameter int AW = 3,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          push,
  input  logic          pop,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          almost_full,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   occupancy,
  output logic          error,
  output logic [1:0]    error_cause
);
  import fifo_fc_pkg::*;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  logic [AW:0] count_q, count_d, af_th, ae_th;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic push_ok, pop_ok, ovf, udf, valid_q, valid_d;
  logic [1:0] err_now, err_q, err_d;
  fc_state_e state_q, state_d;
  always_comb begin
    pop_ok = pop && count_q != '0;
    push_ok = push && (count_q != FULL || pop_ok);
    ovf = push && !push_ok;
    udf = pop && !pop_ok;
    err_now = ovf && udf ? ERR_BOTH : ovf ? ERR_OVF : udf ? ERR_UDF : ERR_NONE;
    count_d = !reset ? '0 : count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    wr_ptr_d = !reset ? '0 : wr_ptr_q + AW'(push_ok);
    rd_ptr_d = !reset ? '0 : rd_ptr_q + AW'(pop_ok);
    valid_d = reset && pop_ok;
`ifdef FIFO_FC_STICKY_ERR_EN
    err_d = !reset ? ERR_NONE : err_q | err_now;
`else
    err_d = !reset ? ERR_NONE : err_now;
`endif
    af_th = umbral_almost_full > FULL ? FULL : umbral_almost_full;
    ae_th = umbral_almost_empty > FULL ? FULL : umbral_almost_empty;
  end
  always_ff @(posedge clk) begin
    count_q <= count_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    valid_q <= valid_d;
    err_q <= err_d;
  end
  always_ff @(posedge clk) state_q <= state_d;
  // Only the current state's own check runs, so inverted thresholds cannot oscillate within a cycle.
  always_comb begin
    state_d = !reset ? ST_RESET :
              state_q == ST_RESET ? ST_NORMAL :
              state_q == ST_NORMAL && count_d >= af_th ? ST_PAUSE :
              state_q == ST_PAUSE && count_d <= ae_th ? ST_NORMAL : state_q;
  end
  always_comb almost_full = state_q == ST_PAUSE;
  fifo_fc_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok && reset),
    .re    (pop_ok),
    .waddr (wr_ptr_q),
    .raddr (rd_ptr_q),
    .wdata (data_in),
    .rdata (data_out)
  );
  assign valid_out = valid_q;
  assign fifo_empty = count_q == '0;
  assign fifo_full = count_q == FULL;
  assign occupancy = count_q;
  assign error = |err_q;
  assign error_cause = err_q;
endmodule
